// File: rtl/mcs4_phase_decoder.sv
// mcs4_phase_decoder: decodes MCS-4 PHI1/PHI2/SYNC into phase strobes, subcycle index, lock and fault strobes
module mcs4_phase_decoder #(
   parameter int TIMEOUT    = 12,
   parameter int LOCK_SYNCS = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       PHI1_i,
   input  logic       PHI2_i,
   input  logic       SYNC_i,
   output logic       phi1_fall_o,
   output logic       phi2_rise_o,
   output logic [2:0] subcycle_o,
   output logic       locked_o,
   output logic       sync_err_o,
   output logic       clk_err_o
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
   localparam logic [2:0] LOCK_N = 3'(LOCK_SYNCS);
   logic          p1_q, p2_q, to_fired;
   logic [2:0]    sync_cnt, sync_cnt_n;
   logic [TW-1:0] to_cnt;
   logic          fall, rise, ovl, tmo, fault, bad, at_x3, locked_n;
   always_comb begin
      fall       = p1_q & ~PHI1_i;
      rise       = ~p2_q & PHI2_i;
      ovl        = ~PHI1_i & ~PHI2_i;
      tmo        = (to_cnt == TO_MAX) & ~to_fired;
      fault      = ovl | tmo;
      at_x3      = subcycle_o == 3'd7;
      // a SYNC is bad when it lands off X3 (after a first one) or is absent at X3
      bad        = rise & (SYNC_i ? at_x3 : (sync_cnt != 3'd0 && !at_x3));
      sync_cnt_n = !rise ? sync_cnt :
                   SYNC_i ? (at_x3 ? 3'd0 : sync_cnt) :
                   (sync_cnt == 3'd0 || !at_x3) ? 3'd1 :
                   (sync_cnt == LOCK_N) ? LOCK_N : sync_cnt + 3'd1;
      locked_n   = fault ? 1'b0 : (rise && sync_cnt_n == LOCK_N) ? 1'b1 : bad ? 1'b0 : locked_o;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p1_q        <= 1'b1;
         p2_q        <= 1'b1;
         phi1_fall_o <= 1'b0;
         phi2_rise_o <= 1'b0;
         subcycle_o  <= 3'd0;
         locked_o    <= 1'b0;
         sync_err_o  <= 1'b0;
         clk_err_o   <= 1'b0;
         sync_cnt    <= 3'd0;
         to_cnt      <= '0;
         to_fired    <= 1'b0;
      end else begin
         p1_q        <= PHI1_i;
         p2_q        <= PHI2_i;
         phi1_fall_o <= fall;
         phi2_rise_o <= rise;
         if (rise) subcycle_o <= SYNC_i ? subcycle_o + 3'd1 : 3'd0;
         locked_o    <= locked_n;
         sync_err_o  <= bad & locked_o;
         clk_err_o   <= fault;
         sync_cnt    <= fault ? 3'd0 : sync_cnt_n;
         to_cnt      <= fall ? '0 : (to_cnt == TO_MAX ? to_cnt : to_cnt + 1'b1);
         to_fired    <= fall ? 1'b0 : (tmo | to_fired);
      end
   end
endmodule

// File: tb/tb_mcs4_phase_decoder.sv
// tb_mcs4_phase_decoder: directed MCS-4 clock sequences with a queued cycle model plus scenario checks
module tb_mcs4_phase_decoder;
   localparam int TIMEOUT = 12;
   localparam int LOCK    = 2;
   logic       clk = 1'b0, rst = 1'b1, phi1 = 1'b1, phi2 = 1'b1, sync = 1'b1;
   logic       phi1_fall, phi2_rise, locked, sync_err, clk_err;
   logic [2:0] sub;
   int         total = 0, passed = 0, failed = 0, cyc = 0, c0 = 0;
   int         n_serr = 0, n_cerr = 0, n_fall = 0, n_rise = 0, first_cerr = -1;
   logic [7:0] exp_q[$];
   bit         m_p1 = 1, m_p2 = 1, m_lock = 0, m_fired = 0;
   int         m_sub = 0, m_cnt = 0, m_to = 0;

   always #5 clk = ~clk;

   mcs4_phase_decoder #(.TIMEOUT(TIMEOUT), .LOCK_SYNCS(LOCK)) dut (
      .clk_i(clk), .rst_i(rst), .PHI1_i(phi1), .PHI2_i(phi2), .SYNC_i(sync),
      .phi1_fall_o(phi1_fall), .phi2_rise_o(phi2_rise), .subcycle_o(sub),
      .locked_o(locked), .sync_err_o(sync_err), .clk_err_o(clk_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   // reference behaviour: expected outputs after the coming edge, queued at drive time
   task automatic model(input bit r, input bit p1, input bit p2, input bit s);
      bit fall, rise, tmo, flt, serr, nlock;
      int nsub, ncnt;
      if (r) begin
         m_p1 = 1; m_p2 = 1; m_sub = 0; m_cnt = 0; m_lock = 0; m_to = 0; m_fired = 0;
         exp_q.push_back(8'h00);
         return;
      end
      fall = m_p1 && !p1;
      rise = !m_p2 && p2;
      tmo  = (m_to >= TIMEOUT) && !m_fired;
      flt  = tmo || (!p1 && !p2);
      nsub = m_sub; ncnt = m_cnt; nlock = m_lock; serr = 0;
      if (rise) begin
         nsub = s ? (m_sub + 1) % 8 : 0;
         if (!s && m_cnt == 0) ncnt = 1;
         else if (!s && m_sub == 7) ncnt = (m_cnt < LOCK) ? m_cnt + 1 : LOCK;
         else if (!s || m_sub == 7) begin
            ncnt = s ? 0 : 1;
            serr = m_lock;
            nlock = 0;
         end
         if (ncnt == LOCK) nlock = 1;
      end
      if (flt) begin
         nlock = 0;
         ncnt = 0;
      end
      exp_q.push_back({fall, rise, 3'(nsub), nlock, serr, flt});
      m_fired = fall ? 1'b0 : (m_fired || tmo);
      m_to    = fall ? 0 : (m_to < TIMEOUT ? m_to + 1 : m_to);
      m_p1 = p1; m_p2 = p2; m_sub = nsub; m_cnt = ncnt; m_lock = nlock;
   endtask

   task automatic step(input bit r, input bit p1, input bit p2, input bit s);
      @(negedge clk);
      rst = r; phi1 = p1; phi2 = p2; sync = s;
      model(r, p1, p2, s);
      @(posedge clk);
      #1;
      cyc++;
      check("outputs", {phi1_fall, phi2_rise, sub, locked, sync_err, clk_err}, exp_q.pop_front());
      if (sync_err) n_serr++;
      if (phi1_fall) n_fall++;
      if (phi2_rise) n_rise++;
      if (clk_err) begin
         n_cerr++;
         if (first_cerr < 0) first_cerr = cyc;
      end
   endtask

   task automatic phase_step(input int t, input bit s, input bit r);
      step(r, t >= 2, t < 5, s);
   endtask

   task automatic period(input bit s);
      for (int t = 0; t < 7; t++) phase_step(t, s, 1'b0);
   endtask

   task automatic lock_up();
      for (int q = 0; q < 10; q++) period(!(q == 1 || q == 9));
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
      check("reset_sub", sub, 0);
      // nominal clocking, SYNC every 8th PHI period
      for (int k = 0; k < 18; k++) begin
         period(k % 8 != 1);
         if (k == 8) check("t1_unlocked_before_2nd_sync", locked, 0);
      end
      check("t1_locked", locked, 1);
      check("t1_falls", n_fall, 18);
      check("t1_rises", n_rise, 17);
      check("t1_sub_after_sync", sub, 0);
      // misplaced SYNC at subcycle 3, relock, then a missing SYNC
      n_serr = 0;
      for (int k = 18; k < 38; k++) begin
         period(!(k == 21 || k == 29));
         if (k == 21) begin
            check("t2_serr", n_serr, 1);
            check("t2_unlocked", locked, 0);
            check("t2_sub", sub, 0);
         end
         if (k == 29) check("t2_relocked", locked, 1);
         if (k == 37) begin
            check("t3_serr", n_serr, 2);
            check("t3_unlocked", locked, 0);
            check("t3_sub", sub, 0);
         end
      end
      // PHI1 stuck high from reset release
      step(1, 1, 1, 1);
      c0 = cyc; first_cerr = -1; n_cerr = 0;
      for (int i = 0; i < 30; i++) step(0, 1, 1, 1);
      check("t4_cerr_delay", first_cerr - c0, 13);
      check("t4_cerr_count", n_cerr, 1);
      check("t4_unlocked", locked, 0);
      // PHI overlap while locked
      lock_up();
      check("t5_locked", locked, 1);
      period(1);
      n_cerr = 0;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("t5_cerr_count", n_cerr, 2);
      check("t5_unlocked", locked, 0);
      step(0, 1, 1, 1);
      step(0, 1, 1, 1);
      check("t5_cerr_stops", n_cerr, 2);
      // reset at subcycle 5 while locked, then relock
      lock_up();
      check("t6_locked", locked, 1);
      for (int q = 10; q < 14; q++) period(1);
      phase_step(0, 1, 0);
      phase_step(1, 1, 0);
      check("t6_sub5", sub, 5);
      check("t6_locked_pre", locked, 1);
      phase_step(2, 1, 1);
      check("t6_reset_outputs", {phi1_fall, phi2_rise, sub, locked, sync_err, clk_err}, 0);
      for (int q = 0; q < 10; q++) begin
         period(!(q == 1 || q == 9));
         if (q == 8) check("t6_one_sync_not_locked", locked, 0);
      end
      check("t6_relocked", locked, 1);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
